// File: rtl/cache_ctrl_nway_pkg.sv
// cache_ctrl_nway_pkg: shared types and helpers for the N-way cache controller.
// Package cache_types provides:
//   cache_state_e  - controller FSM state (COMPARE, WRITEBACK, FILL)
//   plru_width()   - tree pseudo-LRU bit count per set for a given way count
package cache_types;

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } cache_state_e;

    function automatic int plru_width(input int ways);
        return ways - 1;
    endfunction

endpackage

// File: rtl/cache_ctrl_nway_if.sv
// cache_ctrl_nway_if: bus bundle between the cache controller and its environment.
// Carries the CPU request/response, per-set way metadata, PLRU tree access,
// way-array enables and the physical-memory handshake.
// Modports:
//   master - the controller (drives enables, mem_resp, pmem_read/pmem_write)
//   slave  - the environment (CPU, way arrays, PLRU array, physical memory)
// Optional feature macro: CACHE_PERF_CNT_EN adds hit_count/miss_count/wb_count.
interface cache_ctrl_nway_if
    import cache_types::*;
#(
    parameter int WAYS   = 4,
    parameter int WAY_W  = $clog2(WAYS),
    parameter int PLRU_W = plru_width(WAYS)
) ();

    logic              mem_read;
    logic              mem_write;
    logic              mem_resp;
    logic [WAYS-1:0]   hit_vec;
    logic [WAYS-1:0]   valid_vec;
    logic [WAYS-1:0]   dirty_vec;
    logic [PLRU_W-1:0] plru_bits;
    logic [PLRU_W-1:0] plru_next;
    logic              load_plru;
    logic [WAY_W-1:0]  way_sel;
    logic [WAYS-1:0]   load_data;
    logic [WAYS-1:0]   load_tag;
    logic [WAYS-1:0]   load_meta;
    logic              dirty_in;
    logic              fill_sel;
    logic              addr_sel;
    logic              pmem_read;
    logic              pmem_write;
    logic              pmem_resp;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;
    logic [31:0]       wb_count;
`endif

    modport master (
`ifdef CACHE_PERF_CNT_EN
        output hit_count, miss_count, wb_count,
`endif
        input  mem_read, mem_write, hit_vec, valid_vec, dirty_vec, plru_bits, pmem_resp,
        output mem_resp, plru_next, load_plru, way_sel, load_data, load_tag, load_meta,
        output dirty_in, fill_sel, addr_sel, pmem_read, pmem_write
    );

    modport slave (
`ifdef CACHE_PERF_CNT_EN
        input  hit_count, miss_count, wb_count,
`endif
        output mem_read, mem_write, hit_vec, valid_vec, dirty_vec, plru_bits, pmem_resp,
        input  mem_resp, plru_next, load_plru, way_sel, load_data, load_tag, load_meta,
        input  dirty_in, fill_sel, addr_sel, pmem_read, pmem_write
    );

endinterface

// File: rtl/cache_ctrl_nway_plru_tree.sv
// plru_tree: combinational tree pseudo-LRU victim select and access update.
// Node i has children 2i+1/2i+2; leaves map to ways left to right.
// A node bit of 0 means the LRU side is the left subtree.
// Ports:
//   i_bits   - stored tree bits for the set
//   i_way    - way being accessed
//   o_victim - way reached by walking the tree from the root
//   o_bits   - tree with every node on i_way's path pointing away from it
module plru_tree #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         i_bits,
    input  logic [$clog2(WAYS)-1:0] i_way,
    output logic [$clog2(WAYS)-1:0] o_victim,
    output logic [WAYS-2:0]         o_bits
);

    localparam int WAY_W = $clog2(WAYS);

    // One block per tree level: level l holds nodes (2^l)-1 .. 2^(l+1)-2,
    // and decides victim bit WAY_W-1-l (going right sets that bit).
    for (genvar l = 0; l < WAY_W; l++) begin : g_lvl
        localparam int B = (1 << l) - 1;
        localparam int N = 1 << l;
        logic [N-1:0] w_reach;
        logic [N-1:0] w_bits;
        assign w_bits = i_bits[B +: N];
        if (l == 0) begin : g_root
            assign w_reach = 1'b1;
        end else begin : g_child
            for (genvar p = 0; p < N; p++) begin : g_node
                assign w_reach[p] = g_lvl[l-1].w_reach[p/2] &
                                    (g_lvl[l-1].w_bits[p/2] == 1'(p % 2));
            end
        end
        assign o_victim[WAY_W-1-l] = |(w_reach & w_bits);
        // A node is on the accessed way's path when the way's upper l bits
        // equal the node's position in its level.
        for (genvar p = 0; p < N; p++) begin : g_upd
            assign o_bits[B+p] = ((i_way >> (WAY_W - l)) == WAY_W'(p)) ?
                                 ~i_way[WAY_W-1-l] : i_bits[B+p];
        end
    end

endmodule

// File: rtl/cache_ctrl_nway.sv
// cache_ctrl_nway: N-way set-associative write-back cache controller.
// Sits between the CPU port and physical memory and drives the way arrays
// and the per-set tree pseudo-LRU array.
// Ports:
//   clk   - sole clock
//   rst_n - asynchronous active-low reset
//   bus   - cache_ctrl_nway_if master modport (CPU request, set metadata,
//           array enables, pmem handshake)
// Optional feature macro: CACHE_PERF_CNT_EN enables saturating hit/miss/
// writeback counters on bus.hit_count/miss_count/wb_count.
module cache_ctrl_nway
    import cache_types::*;
#(
    parameter int WAYS   = 4,
    parameter int WAY_W  = $clog2(WAYS),
    parameter int PLRU_W = plru_width(WAYS)
) (
    input  logic               clk,
    input  logic               rst_n,
    cache_ctrl_nway_if.master  bus
);

    cache_state_e      r_state;
    cache_state_e      w_state_nxt;
    logic [WAY_W-1:0]  r_victim;
    logic [WAY_W-1:0]  w_victim_nxt;
    logic [WAY_W-1:0]  w_hit_way;
    logic [WAY_W-1:0]  w_inv_way;
    logic [WAY_W-1:0]  w_plru_victim;
    logic [WAY_W-1:0]  w_victim;
    logic [PLRU_W-1:0] w_plru_upd;
    logic [WAYS-1:0]   w_hit_oh;
    logic [WAYS-1:0]   w_fill_oh;
    logic              w_req;
    logic              w_hit;
    logic              w_has_inv;
    logic              w_victim_dirty;

    assign w_req     = bus.mem_read | bus.mem_write;
    assign w_hit     = |bus.hit_vec;
    assign w_has_inv = ~&bus.valid_vec;

    // Descending scan so the lowest index wins (multi-hit and invalid-first).
    always_comb begin
        w_hit_way = '0;
        w_inv_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (bus.hit_vec[i])
                w_hit_way = WAY_W'(i);
            if (!bus.valid_vec[i])
                w_inv_way = WAY_W'(i);
        end
    end

    plru_tree #(.WAYS(WAYS)) u_plru (
        .i_bits   (bus.plru_bits),
        .i_way    (w_hit_way),
        .o_victim (w_plru_victim),
        .o_bits   (w_plru_upd)
    );

    assign w_victim       = w_has_inv ? w_inv_way : w_plru_victim;
    assign w_victim_dirty = bus.valid_vec[w_victim] & bus.dirty_vec[w_victim];
    assign w_hit_oh       = WAYS'(1) << w_hit_way;
    assign w_fill_oh      = WAYS'(1) << r_victim;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= COMPARE;
            r_victim <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_victim <= w_victim_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_victim_nxt   = r_victim;
        bus.mem_resp   = 1'b0;
        bus.plru_next  = bus.plru_bits;
        bus.load_plru  = 1'b0;
        bus.way_sel    = '0;
        bus.load_data  = '0;
        bus.load_tag   = '0;
        bus.load_meta  = '0;
        bus.dirty_in   = 1'b0;
        bus.fill_sel   = 1'b0;
        bus.addr_sel   = 1'b0;
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        case (r_state)
            COMPARE: begin
                if (w_req && w_hit) begin
                    bus.mem_resp  = 1'b1;
                    bus.way_sel   = w_hit_way;
                    bus.load_plru = 1'b1;
                    bus.plru_next = w_plru_upd;
                    // A write (including read+write together) marks the line dirty.
                    if (bus.mem_write) begin
                        bus.load_data = w_hit_oh;
                        bus.load_meta = w_hit_oh;
                        bus.dirty_in  = 1'b1;
                    end
                end else if (w_req) begin
                    w_victim_nxt = w_victim;
                    w_state_nxt  = w_victim_dirty ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                bus.pmem_write = 1'b1;
                bus.addr_sel   = 1'b1;
                bus.way_sel    = r_victim;
                if (bus.pmem_resp)
                    w_state_nxt = FILL;
            end
            FILL: begin
                bus.pmem_read = 1'b1;
                bus.fill_sel  = 1'b1;
                if (bus.pmem_resp) begin
                    bus.load_data = w_fill_oh;
                    bus.load_tag  = w_fill_oh;
                    bus.load_meta = w_fill_oh;
                    w_state_nxt   = COMPARE;
                end
            end
            default: w_state_nxt = COMPARE;
        endcase
    end

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;
    logic [31:0] r_wb_cnt;
    logic        w_cnt_hit;
    logic        w_cnt_miss;
    logic        w_cnt_wb;

    assign w_cnt_hit  = (r_state == COMPARE) & w_req & w_hit;
    assign w_cnt_miss = (r_state == COMPARE) & w_req & ~w_hit;
    assign w_cnt_wb   = (r_state == WRITEBACK) & bus.pmem_resp;

    // Increment is suppressed once a counter reaches all ones (saturation).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_wb_cnt   <= '0;
        end else begin
            r_hit_cnt  <= r_hit_cnt + 32'(w_cnt_hit & ~&r_hit_cnt);
            r_miss_cnt <= r_miss_cnt + 32'(w_cnt_miss & ~&r_miss_cnt);
            r_wb_cnt   <= r_wb_cnt + 32'(w_cnt_wb & ~&r_wb_cnt);
        end
    end

    assign bus.hit_count  = r_hit_cnt;
    assign bus.miss_count = r_miss_cnt;
    assign bus.wb_count   = r_wb_cnt;
`endif

endmodule
